// File: rtl/jstk2_spi_master.sv
// jstk2_spi_master: SPI mode-0 master that polls a PmodJSTK2 joystick.
//
// Each transaction sends {0x84, R, G, B, 0x00} MSB first while collecting five reply bytes.
// The reply bytes are decoded into x_pos/y_pos/button, which are all written on the same edge
// as a one-cycle data_valid pulse.
//
// Timing, in CLK cycles:
//   - SS is low from the edge that leaves IDLE to the edge that leaves DONE.
//     That is SS_SETUP + 80*CLK_HALF + 4*BYTE_GAP + 1 cycles. This is one less than the nominal
//     count, which also includes the IDLE exit cycle.
//   - busy covers exactly the same window as SS low.
//   - data_valid pulses in the first IDLE cycle, together with SS high.
//   - The first SCLK rise comes SS_SETUP + CLK_HALF cycles after SS falls.
//   - SS stays high for exactly POLL_CYCLES cycles between transactions.
//
// Parameter minimums: CLK_HALF, SS_SETUP, BYTE_GAP and POLL_CYCLES must all be at least 1.
module jstk2_spi_master #(
    parameter int unsigned CLK_HALF    = 12,
    parameter int unsigned SS_SETUP    = 180,
    parameter int unsigned BYTE_GAP    = 120,
    parameter int unsigned POLL_CYCLES = 120000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:0] color,
    input  logic        MISO,
    output logic        SS,
    output logic        SCLK,
    output logic        MOSI,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [1:0]  button,
    output logic        data_valid,
    output logic        busy
);

    localparam int unsigned PollW  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned CntMax = (SS_SETUP > CLK_HALF) ?
                                     ((SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP) :
                                     ((CLK_HALF > BYTE_GAP) ? CLK_HALF : BYTE_GAP);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [PollW-1:0] PollLast  = PollW'(POLL_CYCLES - 1);
    localparam logic [CntW-1:0]  SetupLast = CntW'(SS_SETUP - 1);
    localparam logic [CntW-1:0]  HalfLast  = CntW'(CLK_HALF - 1);
    localparam logic [CntW-1:0]  GapLast   = CntW'(BYTE_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StGap,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [PollW-1:0]  poll_q, poll_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic [39:0]       tx_q, tx_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic [7:0]        rx0_q, rx0_d;
    logic [1:0]        rx1_q, rx1_d;
    logic [7:0]        rx2_q, rx2_d;
    logic [1:0]        rx3_q, rx3_d;
    logic [1:0]        rx4_q, rx4_d;
    logic              ss_q, ss_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic [1:0]        btn_q, btn_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    // Next-state logic: the sequencer, the SCLK phase counter and both shift registers.
    always_comb begin
        state_d = state_q;
        poll_d  = poll_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        rx0_d   = rx0_q;
        rx1_d   = rx1_q;
        rx2_d   = rx2_q;
        rx3_d   = rx3_q;
        rx4_d   = rx4_q;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        x_d     = x_q;
        y_d     = y_q;
        btn_d   = btn_q;
        valid_d = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            StIdle: begin
                if (poll_q == PollLast) begin
                    poll_d  = '0;
                    // color is captured only here, so later changes wait for the next frame.
                    tx_d    = {8'h84, color, 8'h00};
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = StSetup;
                end else begin
                    poll_d = poll_q + PollW'(1);
                end
            end

            StSetup: begin
                if (cnt_q == SetupLast) begin
                    cnt_d   = '0;
                    mosi_d  = tx_q[39];
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StShift: begin
                if (cnt_q != HalfLast) begin
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: MISO has been stable since the previous falling edge.
                        rx_sh_d = {rx_sh_q[6:0], MISO};
                    end else begin
                        // Falling edge: advance MOSI. Across a byte boundary this already
                        // presents the next byte's MSB for the gap.
                        tx_d   = {tx_q[38:0], 1'b0};
                        mosi_d = tx_q[38];
                        bit_d  = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            case (byte_q)
                                3'd0:    rx0_d = rx_sh_q;
                                3'd1:    rx1_d = rx_sh_q[1:0];
                                3'd2:    rx2_d = rx_sh_q;
                                3'd3:    rx3_d = rx_sh_q[1:0];
                                default: rx4_d = rx_sh_q[1:0];
                            endcase
                            byte_d  = byte_q + 3'd1;
                            state_d = (byte_q == 3'd4) ? StDone : StGap;
                        end
                    end
                end
            end

            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StDone: begin
                x_d     = {rx1_q, rx0_q};
                y_d     = {rx3_q, rx2_q};
                btn_d   = rx4_q;
                valid_d = 1'b1;
                ss_d    = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers. Reset also clears partial reply bytes mid-frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            poll_q  <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx0_q   <= '0;
            rx1_q   <= '0;
            rx2_q   <= '0;
            rx3_q   <= '0;
            rx4_q   <= '0;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            btn_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx0_q   <= rx0_d;
            rx1_q   <= rx1_d;
            rx2_q   <= rx2_d;
            rx3_q   <= rx3_d;
            rx4_q   <= rx4_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            x_q     <= x_d;
            y_q     <= y_d;
            btn_q   <= btn_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign SS         = ss_q;
    assign SCLK       = sclk_q;
    assign MOSI       = mosi_q;
    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign button     = btn_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_jstk2_spi_master.sv
// Testbench for jstk2_spi_master.
// A joystick slave model drives MISO, collects MOSI and checks SPI framing.
// Expected frames and decoded results are queued by the stimulus and popped by the monitor.
module tb_jstk2_spi_master;

    localparam int unsigned CLK_HALF    = 2;
    localparam int unsigned SS_SETUP    = 4;
    localparam int unsigned BYTE_GAP    = 3;
    localparam int unsigned POLL_CYCLES = 10;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [23:0] color = 24'h0;
    logic        MISO;
    logic        SS;
    logic        SCLK;
    logic        MOSI;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [1:0]  button;
    logic        data_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  resp [5];
    logic [39:0] exp_frame_q [$];
    logic [21:0] exp_res_q [$];   // {x_pos, y_pos, button}
    int          bit_idx = 0;
    logic        abort = 1'b0;
    int          idle_viol = 0;
    int          busy_viol = 0;

    jstk2_spi_master #(
        .CLK_HALF   (CLK_HALF),
        .SS_SETUP   (SS_SETUP),
        .BYTE_GAP   (BYTE_GAP),
        .POLL_CYCLES(POLL_CYCLES)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .color     (color),
        .MISO      (MISO),
        .SS        (SS),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .button    (button),
        .data_valid(data_valid),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model and protocol monitor, sampled 1 time unit after each rising CLK edge.
    initial begin
        logic        prev_ss, prev_sclk, prev_mosi;
        int          t, rises, low_run, idle_run;
        logic [39:0] frame;
        logic [39:0] ef;
        logic [21:0] er;
        prev_ss   = 1'b1;
        prev_sclk = 1'b0;
        prev_mosi = 1'b0;
        t         = 0;
        rises     = 0;
        low_run   = 0;
        idle_run  = 0;
        frame     = '0;
        MISO      = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (SS === 1'b1 && SCLK !== 1'b0) idle_viol++;
            if (busy !== ~SS) busy_viol++;

            if (prev_ss === 1'b1 && SS === 1'b0) begin
                check("ss_high_gap_min", idle_run >= POLL_CYCLES, 1'b1);
                t       = 0;
                rises   = 0;
                frame   = '0;
                bit_idx = 0;
                low_run = 0;
                MISO    = resp[0][7];
            end else if (SS === 1'b0) begin
                t++;
                if (prev_sclk === 1'b0 && SCLK === 1'b1) begin
                    rises++;
                    check("mosi_stable_at_rise", MOSI, prev_mosi);
                    frame = {frame[38:0], MOSI};
                    if (rises == 1) check("ss_fall_to_first_rise", t, 6);
                    else if ((rises - 1) % 8 == 0)
                        check("byte_gap_min", low_run >= BYTE_GAP, 1'b1);
                end
                if (prev_sclk === 1'b1 && SCLK === 1'b0) begin
                    bit_idx++;
                    low_run = 0;
                    MISO = (bit_idx < 40) ? resp[bit_idx / 8][7 - (bit_idx % 8)] : 1'b0;
                end
                if (SCLK === 1'b0) low_run++;
            end

            if (prev_ss === 1'b0 && SS === 1'b1) begin
                t++;
                if (abort) begin
                    abort = 1'b0;
                end else begin
                    check("sclk_rises_per_frame", rises, 40);
                    check("ss_low_cycles", t, 177);
                    if (exp_frame_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mosi_frame: got 0x%0h, expected none queued", frame);
                    end else begin
                        ef = exp_frame_q.pop_front();
                        check("mosi_frame", frame, ef);
                    end
                end
                idle_run = 0;
            end
            if (SS === 1'b1) idle_run++;

            if (data_valid === 1'b1) begin
                if (exp_res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got x=%0h y=%0h b=%0h, expected no pulse",
                             x_pos, y_pos, button);
                end else begin
                    er = exp_res_q.pop_front();
                    check("x_pos", x_pos, er[21:12]);
                    check("y_pos", y_pos, er[11:2]);
                    check("button", button, er[1:0]);
                    check("ss_high_at_valid", SS, 1'b1);
                end
            end

            prev_ss   = SS;
            prev_sclk = SCLK;
            prev_mosi = MOSI;
        end
    end

    task automatic load_txn(input logic [39:0] rsp, input logic [39:0] exp_frame,
                            input logic [21:0] exp_res, input logic push_res);
        for (int i = 0; i < 5; i++) resp[i] = rsp[39 - 8*i -: 8];
        exp_frame_q.push_back(exp_frame);
        if (push_res) exp_res_q.push_back(exp_res);
    endtask

    task automatic wait_ss(input logic v, input string what);
        int n = 0;
        while (SS !== v && n < 1000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(what, SS, v);
    endtask

    task automatic wait_bits(input int target, input string what);
        int n = 0;
        while (bit_idx < target && n < 1000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(what, bit_idx >= target, 1'b1);
    endtask

    task automatic count_to_fall(input string what);
        int n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (SS !== 1'b0 && n < 100);
        check(what, n, 10);
        check({what, "_busy"}, busy, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss"}, SS, 1'b1);
        check({tag, "_sclk"}, SCLK, 1'b0);
        check({tag, "_mosi"}, MOSI, 1'b0);
        check({tag, "_x"}, x_pos, 10'd0);
        check({tag, "_y"}, y_pos, 10'd0);
        check({tag, "_button"}, button, 2'd0);
        check({tag, "_valid"}, data_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) resp[i] = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");

        // Frame 0: colour FF8001, replies 34 02 CD 03 02.
        color = 24'hFF8001;
        load_txn(40'h34_02_CD_03_02, 40'h84_FF8001_00, {10'h234, 10'h3CD, 2'b10}, 1'b1);
        RST = 1'b0;
        count_to_fall("first_ss_fall");
        wait_ss(1'b1, "frame0_end");

        // Frame 1: all-ones reply; colour changes during byte 2 and must not reach this frame.
        color = 24'h000000;
        load_txn(40'hFF_FF_FF_FF_FF, 40'h84_000000_00, {10'd1023, 10'd1023, 2'b11}, 1'b1);
        wait_ss(1'b0, "frame1_start");
        wait_bits(20, "frame1_mid_byte2");
        color = 24'h00FF00;
        wait_ss(1'b1, "frame1_end");

        // Frame 2: picks up the new colour.
        load_txn(40'h00_01_55_02_01, 40'h84_00FF00_00, {10'h100, 10'h255, 2'b01}, 1'b1);
        wait_ss(1'b0, "frame2_start");
        wait_ss(1'b1, "frame2_end");

        // Frame 3: reset during byte 3, so no frame or result is expected.
        for (int i = 0; i < 5; i++) resp[i] = 8'hA5;
        wait_ss(1'b0, "frame3_start");
        wait_bits(28, "frame3_byte3");
        abort = 1'b1;
        RST   = 1'b1;
        @(posedge CLK);
        #1;
        check_reset_outputs("abort");

        // Frame 4: normal operation after the aborted frame.
        color = 24'h123456;
        load_txn(40'h12_00_34_01_00, 40'h84_123456_00, {10'h012, 10'h134, 2'b00}, 1'b1);
        RST = 1'b0;
        count_to_fall("ss_fall_after_abort");
        wait_ss(1'b1, "frame4_end");

        repeat (3) @(posedge CLK);
        #1;
        check("results_outstanding", exp_res_q.size(), 0);
        check("frames_outstanding", exp_frame_q.size(), 0);
        check("sclk_active_while_ss_high", idle_viol, 0);
        check("busy_vs_ss", busy_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jstk2_spi_master.md
Name: jstk2_spi_master

Overview:
- SPI master that polls the PmodJSTK2 joystick and feeds the LED/status stage downstream.
- Each transaction does two things:
  - Sends the "set RGB LED" command with the current 24-bit colour.
  - Receives the joystick X/Y position and the two button bits.
- Decoded results are held stable between transactions and updated atomically with a one-cycle valid strobe.

Parameters:
- CLK_HALF, 12: SCLK half-period in CLK cycles (12 MHz / 24 = 500 kHz); minimum 1.
- SS_SETUP, 180: CLK cycles from SS falling to first SCLK activity (15 us).
- BYTE_GAP, 120: idle CLK cycles between consecutive bytes, SCLK low (10 us).
- POLL_CYCLES, 120000: IDLE dwell in CLK cycles before each transaction (10 ms); minimum 1.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- color  in  24  {R,G,B} sent to the joystick LED; sampled once per transaction
- MISO  in  1  serial data from joystick
- SS  out  1  slave select, active-low
- SCLK  out  1  SPI clock, mode 0 (idle low)
- MOSI  out  1  serial data to joystick
- x_pos  out  10  joystick X, 0..1023
- y_pos  out  10  joystick Y, 0..1023
- button  out  2  bit1 = trigger, bit0 = stick press (1 = pressed)
- data_valid  out  1  one-cycle pulse when x_pos/y_pos/button update
- busy  out  1  high from leaving IDLE through DONE inclusive

Behaviour:
- Reset state (RST high at a CLK edge):
  - SS=1, SCLK=0, MOSI=0, x_pos=0, y_pos=0, button=0, data_valid=0, busy=0.
  - State=IDLE; poll counter, bit counter and byte counter all 0.
  - Applies mid-transaction too: SS rises on the next edge, no partial data is written, no data_valid pulse.
- States: IDLE -> SETUP -> SHIFT -> (GAP -> SHIFT)x4 -> DONE -> IDLE.
- IDLE:
  - Poll counter increments each cycle.
  - At POLL_CYCLES-1: clear counter, latch color into tx buffer, drive SS=0, go to SETUP.
- SETUP:
  - Hold SS=0, SCLK=0 for SS_SETUP cycles.
  - Present MSB of byte 0 on MOSI, then go to SHIFT.
- Transmit frame, 5 bytes, MSB first: 0x84, R=color[23:16], G=color[15:8], B=color[7:0], 0x00.
- SHIFT, per bit:
  - SCLK low for CLK_HALF cycles, then high for CLK_HALF cycles.
  - MISO is sampled into the rx shift register on the cycle SCLK rises.
  - MOSI changes only on the cycle SCLK falls, or on entry to SHIFT.
  - Each bit takes 2*CLK_HALF cycles. After the 8th falling edge, the byte is stored in rx slot [byte index].
- GAP:
  - Entered after bytes 0-3. SCLK=0, SS=0 for BYTE_GAP cycles.
  - MOSI = MSB of the next byte, then back to SHIFT.
- After byte 4: go to DONE.
- DONE, one cycle:
  - Outputs update together:
    - x_pos = {rx1[1:0], rx0}
    - y_pos = {rx3[1:0], rx2}
    - button = rx4[1:0]
  - Upper bits of rx1/rx3 and rx4[7:2] are ignored.
  - data_valid=1; SS returns to 1 on the same edge; MOSI=0. Next cycle: IDLE, busy=0.
- color changes during a transaction have no effect until the next IDLE->SETUP latch.
- No back-to-back transactions: at least POLL_CYCLES cycles with SS=1 between transactions.
- SCLK never toggles while SS=1; exactly 40 rising edges per transaction.
- Transaction length: 1 + SS_SETUP + 40*2*CLK_HALF + 4*BYTE_GAP + 1 cycles (±1 for state-entry registration, fixed per implementation and documented in the RTL header).

Test Plan:
- Reset then idle, with CLK_HALF=2, SS_SETUP=4, BYTE_GAP=3, POLL_CYCLES=10 -> SS=1, SCLK=0, outputs 0; first SS fall exactly 10 cycles after RST deasserts; busy rises with it.
- color=0xFF8001, model slave returns 0x34,0x02,0xCD,0x03,0x02 -> MOSI bytes 0x84,0xFF,0x80,0x01,0x00; x_pos=0x234, y_pos=0x3CD, button=2'b10; data_valid high exactly one cycle; SS high the same cycle.
- Slave returns 0xFF,0xFF,0xFF,0xFF,0xFF -> x_pos=1023, y_pos=1023, button=2'b11 (upper bits masked).
- color changed from 0x000000 to 0x00FF00 mid-byte-2 -> current frame sends G=0x00; next frame sends 0xFF.
- RST pulsed during byte 3 -> SS=1 and SCLK=0 next cycle; previous x_pos/y_pos cleared to 0; no data_valid; next transaction starts POLL_CYCLES after RST release.
- Protocol checker over 3 consecutive transactions -> 40 SCLK rises per SS-low window; SS-fall to first SCLK rise = SS_SETUP+CLK_HALF cycles; inter-byte SCLK-low gap ≥ BYTE_GAP; MOSI stable across every rising edge.
